// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM slot bridge: FSM states, write
// setup/hold lengths and the byte-lane helper.
package sram_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SU,
        ST_WR_PL,
        ST_WR_HD,
        ST_DONE
    } state_t;

    localparam int WR_SETUP_CYC = 1;
    localparam int WR_HOLD_CYC  = 1;

    // Byte enables belonging to one 16-bit half of the 32-bit word.
    function automatic logic [1:0] lane_mask(input logic [3:0] be, input logic half);
        return half ? be[3:2] : be[1:0];
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable 4-bit down-counter that times one SRAM phase; it stops at zero
// rather than wrapping, so the zero flag stays up until the next load.
module sram_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/sram_bus_bridge.sv
// 32-bit bus slot to 16-bit asynchronous SRAM bridge, two halfword phases per word.
// Define SRAM_POSTED_WRITE_EN to acknowledge writes immediately and run them in the background.
module sram_bus_bridge
    import sram_bus_pkg::*;
#(
    parameter int SRAM_AW  = 21,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [21:0]        addr,
    input  logic               we,
    input  logic [3:0]         be,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               nak,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i
);

    localparam int WORD_AW = SRAM_AW - 1;

    state_t               state_reg;
    logic                 half_reg;
    logic [WORD_AW-1:0]   word_addr_reg;
    logic [3:0]           be_reg;
    logic [31:0]          wdata_reg;
    logic [31:0]          rdata_reg;
    logic                 nak_reg;
    logic [SRAM_AW-1:0]   sram_addr_reg;
    logic                 ce_n_reg;
    logic                 oe_n_reg;
    logic                 we_n_reg;
    logic                 ub_n_reg;
    logic                 lb_n_reg;
    logic [15:0]          dq_o_reg;
    logic                 dq_oe_reg;
`ifdef SRAM_POSTED_WRITE_EN
    logic                 posted_reg;
`endif

    logic                 tmr_load;
    logic [3:0]           tmr_val;
    logic                 tmr_zero;
    logic                 first_half;
    logic                 unused_addr;

    assign unused_addr = ^addr[1:0];
    // A write whose low byte pair is empty starts directly on the high half.
    assign first_half  = (lane_mask(be, 1'b0) == 2'b00);

    // Every timed phase ends when the counter reaches zero; load it on entry.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 4'(WAIT_CYC - 1);
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                tmr_load = 1'b1;
                if (we) tmr_val = 4'(WR_SETUP_CYC - 1);
            end
            ST_RD:    tmr_load = tmr_zero;
            ST_WR_SU: tmr_load = tmr_zero;
            ST_WR_PL: begin
                tmr_load = tmr_zero;
                tmr_val  = 4'(WR_HOLD_CYC - 1);
            end
            ST_WR_HD: begin
                tmr_load = tmr_zero;
                tmr_val  = 4'(WR_SETUP_CYC - 1);
            end
            default: ;
        endcase
    end

    sram_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            half_reg      <= 1'b0;
            word_addr_reg <= '0;
            be_reg        <= 4'd0;
            wdata_reg     <= 32'd0;
            rdata_reg     <= 32'd0;
            nak_reg       <= 1'b0;
            sram_addr_reg <= '0;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            ub_n_reg      <= 1'b1;
            lb_n_reg      <= 1'b1;
            dq_o_reg      <= 16'd0;
            dq_oe_reg     <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
            posted_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    state_reg <= ST_IDLE;
                    nak_reg   <= 1'b0;
                    ce_n_reg  <= 1'b1;
                    oe_n_reg  <= 1'b1;
                    we_n_reg  <= 1'b1;
                    ub_n_reg  <= 1'b1;
                    lb_n_reg  <= 1'b1;
                    dq_oe_reg <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
                    // Completion of a posted write is internal: a waiting master keeps nak.
                    if (state_reg == ST_DONE && posted_reg) begin
                        posted_reg <= 1'b0;
                        nak_reg    <= nak_reg;
                    end else
`endif
                    if (en) begin
                        word_addr_reg <= addr[WORD_AW+1:2];
                        be_reg        <= be;
                        wdata_reg     <= wdata;
                        if (!we) begin
                            state_reg     <= ST_RD;
                            half_reg      <= 1'b0;
                            sram_addr_reg <= {addr[WORD_AW+1:2], 1'b0};
                            ce_n_reg      <= 1'b0;
                            oe_n_reg      <= 1'b0;
                            ub_n_reg      <= 1'b0;
                            lb_n_reg      <= 1'b0;
                            nak_reg       <= 1'b1;
                        end else if (be == 4'b0000) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg     <= ST_WR_SU;
                            half_reg      <= first_half;
                            sram_addr_reg <= {addr[WORD_AW+1:2], first_half};
                            dq_o_reg      <= first_half ? wdata[31:16] : wdata[15:0];
                            dq_oe_reg     <= 1'b1;
                            ce_n_reg      <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
                            posted_reg    <= 1'b1;
                            nak_reg       <= 1'b0;
`else
                            nak_reg       <= 1'b1;
`endif
                        end
                    end
                end

                ST_RD: begin
                    if (tmr_zero) begin
                        if (!half_reg) begin
                            rdata_reg[15:0] <= sram_dq_i;
                            half_reg        <= 1'b1;
                            sram_addr_reg   <= {word_addr_reg, 1'b1};
                        end else begin
                            rdata_reg[31:16] <= sram_dq_i;
                            state_reg        <= ST_DONE;
                            nak_reg          <= 1'b0;
                            ce_n_reg         <= 1'b1;
                            oe_n_reg         <= 1'b1;
                            ub_n_reg         <= 1'b1;
                            lb_n_reg         <= 1'b1;
                        end
                    end
                end

                ST_WR_SU: begin
                    if (tmr_zero) begin
                        state_reg            <= ST_WR_PL;
                        we_n_reg             <= 1'b0;
                        {ub_n_reg, lb_n_reg} <= ~lane_mask(be_reg, half_reg);
                    end
                end

                ST_WR_PL: begin
                    if (tmr_zero) begin
                        state_reg <= ST_WR_HD;
                        we_n_reg  <= 1'b1;
                        ub_n_reg  <= 1'b1;
                        lb_n_reg  <= 1'b1;
                    end
                end

                ST_WR_HD: begin
                    if (tmr_zero) begin
                        if (!half_reg && lane_mask(be_reg, 1'b1) != 2'b00) begin
                            state_reg     <= ST_WR_SU;
                            half_reg      <= 1'b1;
                            sram_addr_reg <= {word_addr_reg, 1'b1};
                            dq_o_reg      <= wdata_reg[31:16];
                        end else begin
                            state_reg <= ST_DONE;
                            nak_reg   <= 1'b0;
                            ce_n_reg  <= 1'b1;
                            dq_oe_reg <= 1'b0;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
`ifdef SRAM_POSTED_WRITE_EN
            // A new request arriving behind a posted write waits for it to drain.
            if (posted_reg && en && state_reg != ST_IDLE && state_reg != ST_DONE) begin
                nak_reg <= 1'b1;
            end
`endif
        end
    end

    assign rdata      = rdata_reg;
    assign nak        = nak_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_ce_n  = ce_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign sram_we_n  = we_n_reg;
    assign sram_ub_n  = ub_n_reg;
    assign sram_lb_n  = lb_n_reg;
    assign sram_dq_o  = dq_o_reg;
    assign sram_dq_oe = dq_oe_reg;

endmodule
